// File: rtl/filter_pkg.sv
// Shared types and constants for the time-multiplexed filter controller.
// Holds the controller state encoding, default widths and the clamp helper
// used when the saturating output build (MAC_SAT_EN) is selected.
package filter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        MAC   = 3'd2,
        ROUND = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;

    // Clamp a signed value to the range representable in w bits (w <= 63).
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate: acc += sext(a * b) when en, cleared by clr.
// The full-width product is sign-extended into the accumulator; clear wins
// over enable.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;

    // Full-precision signed product of sample and coefficient.
    always_comb begin
        prod = PROD_W'(a) * PROD_W'(b);
    end

    // Accumulator register; clear has priority over accumulate.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/mac_scheduler.sv
// Time-multiplexed FIR controller: accepts a sample, walks one MAC unit over
// all taps using an external synchronous coefficient ROM, then presents the
// shifted and width-reduced sum on a valid/ready output.
// Build option: define MAC_SAT_EN to clamp the output instead of wrapping.
// A new sample may be taken on the same edge that the held result is
// consumed, giving one result every N_TAPS+3 cycles under full flow.
module mac_scheduler
    import filter_pkg::*;
#(
    parameter int DATA_W = filter_pkg::DATA_W,
    parameter int COEF_W = filter_pkg::COEF_W,
    parameter int N_TAPS = 8,
    parameter int ACC_W  = filter_pkg::ACC_W,
    parameter int OUT_W  = filter_pkg::OUT_W,
    parameter int SHIFT  = 7
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       EN,
    input  logic                       FLUSH,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic signed [DATA_W-1:0]   IN_DATA,
    output logic [$clog2(N_TAPS)-1:0]  COEF_ADDR,
    input  logic signed [COEF_W-1:0]   COEF_DATA,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic signed [OUT_W-1:0]    OUT_DATA,
    output logic                       BUSY
);

    localparam int AW = $clog2(N_TAPS);

    state_t                    state;
    logic signed [DATA_W-1:0]  x [N_TAPS];
    logic [AW-1:0]             k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   reduced;
    logic                      accept;
    logic                      mac_clr;
    logic                      mac_en;

    // Input handshake: open in IDLE, or in HOLD on the cycle the result leaves.
    always_comb begin
        IN_READY = RST_N && EN && !FLUSH &&
                   ((state == IDLE) || ((state == HOLD) && OUT_READY));
        accept   = IN_VALID && IN_READY;
        mac_clr  = FLUSH || accept;
        mac_en   = (state == MAC);
        BUSY     = (state != IDLE);
    end

    // Floor shift and reduction of the finished sum to the output width.
    always_comb begin
        shifted = acc >>> SHIFT;
`ifdef MAC_SAT_EN
        reduced = OUT_W'(saturate(64'(shifted), OUT_W));
`else
        reduced = shifted[OUT_W-1:0];
`endif
    end

    // Delay line: shifts on every accepted sample, cleared by FLUSH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
        end else if (FLUSH) begin
            for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
        end else if (accept) begin
            for (int i = N_TAPS - 1; i > 0; i--) x[i] <= x[i-1];
            x[0] <= IN_DATA;
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (x[k]),
        .b     (COEF_DATA),
        .acc   (acc)
    );

    // Sequencer: ROM addressing runs two taps ahead of the MAC tap index
    // to cover the one-cycle ROM latency.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            k         <= '0;
            COEF_ADDR <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
        end else if (FLUSH) begin
            state     <= IDLE;
            k         <= '0;
            COEF_ADDR <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        k         <= '0;
                        COEF_ADDR <= '0;
                        state     <= PRIME;
                    end
                end
                PRIME: begin
                    COEF_ADDR <= AW'(1);
                    state     <= MAC;
                end
                MAC: begin
                    if (int'(k) + 2 < N_TAPS)
                        COEF_ADDR <= AW'(int'(k) + 2);
                    if (k == AW'(N_TAPS - 1))
                        state <= ROUND;
                    else
                        k <= k + 1'b1;
                end
                ROUND: begin
                    OUT_DATA  <= reduced;
                    OUT_VALID <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        if (accept) begin
                            k         <= '0;
                            COEF_ADDR <= '0;
                            state     <= PRIME;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
// Bench for mac_scheduler: impulse vectors against a behavioural ROM plus
// hand-written sequences for backpressure, flush, reset, enable and streaming.
module tb_mac_scheduler;

    localparam int N = 8;

`ifdef MAC_SAT_EN
    localparam int E_MIN = 32767;
    localparam int E_S1  = 32767;
    localparam int E_S7  = 32767;
`else
    localparam int E_MIN = -32768;
    localparam int E_S1  = -514;
    localparam int E_S7  = -2056;
`endif

    logic               CLK;
    logic               RST_N;
    logic               EN;
    logic               FLUSH;
    logic               IN_VALID;
    logic               IN_READY;
    logic signed [7:0]  IN_DATA;
    logic [2:0]         COEF_ADDR;
    logic signed [15:0] COEF_DATA;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic signed [15:0] OUT_DATA;
    logic               BUSY;

    logic [15:0] rom [N];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic signed [7:0] x;
        logic [15:0]       c0;
        int                exp;
    } vec_t;

    vec_t tv [11];

    mac_scheduler dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .FLUSH     (FLUSH),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .COEF_ADDR (COEF_ADDR),
        .COEF_DATA (COEF_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous coefficient ROM, one cycle of latency.
    always @(posedge CLK) COEF_DATA <= rom[COEF_ADDR];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rom(input logic [15:0] c0, input logic [15:0] c1);
        for (int j = 0; j < N; j++) rom[j] = 16'h0000;
        rom[0] = c0;
        rom[1] = c1;
    endtask

    task automatic flush_pulse();
        @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
    endtask

    // Present one sample and return at the negedge after the accepting edge.
    task automatic send(input logic signed [7:0] xv);
        int n;
        n = 0;
        @(negedge CLK);
        IN_VALID = 1'b1;
        IN_DATA  = xv;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got IN_READY=0 expected 1");
            IN_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            @(negedge CLK);
            IN_VALID = 1'b0;
        end
    endtask

    // Wait for OUT_VALID (counting edges since the accept), then consume it.
    task automatic get_result(output int d, output int lat);
        lat = 0;
        while (!OUT_VALID && lat < 300) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        d = OUT_DATA;
        OUT_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
    endtask

    initial begin
        int d;
        int lat;
        int bad;
        int nacc;
        int nres;
        int res [8];
        int acyc [8];

        tv[0]  = '{  8'sd100,  16'h7FFF,  25599 };
        tv[1]  = '{ -8'sd100,  16'h7FFF, -25600 };
        tv[2]  = '{  8'sd127,  16'h7FFF,  32511 };
        tv[3]  = '{ -8'sd128,  16'h7FFF, -32767 };
        tv[4]  = '{  8'sd1,    16'h0080,      1 };
        tv[5]  = '{ -8'sd1,    16'h0080,     -1 };
        tv[6]  = '{ -8'sd1,    16'h0001,     -1 };
        tv[7]  = '{  8'sd1,    16'h0001,      0 };
        tv[8]  = '{  8'sd0,    16'h7FFF,      0 };
        tv[9]  = '{ -8'sd128,  16'h8000,  E_MIN };
        tv[10] = '{  8'sd127,  16'h8000, -32512 };

        RST_N = 1'b0; EN = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0;
        IN_DATA = '0; OUT_READY = 1'b0;
        set_rom(16'h0000, 16'h0000);
        repeat (3) @(negedge CLK);
        check("rst_in_ready", IN_READY, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_coef_addr", COEF_ADDR, 0);
        check("rst_busy", BUSY, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Impulse vectors: only tap 0 non-zero, delay line cleared first.
        for (int i = 0; i < 11; i++) begin
            flush_pulse();
            set_rom(tv[i].c0, 16'h0000);
            send(tv[i].x);
            get_result(d, lat);
            check($sformatf("vec%0d_data", i), d, tv[i].exp);
            check($sformatf("vec%0d_latency", i), lat, N + 2);
            check($sformatf("vec%0d_valid_clear", i), OUT_VALID, 0);
        end

        // Backpressure with a second sample waiting; it enters on the release edge.
        flush_pulse();
        set_rom(16'h7FFF, 16'h4000);
        send(8'sd100);
        IN_VALID = 1'b1;
        IN_DATA  = -8'sd20;
        lat = 0;
        while (!OUT_VALID && lat < 300) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        check("bp_latency", lat, N + 2);
        d = OUT_DATA;
        check("bp_first_data", d, 25599);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'(d) || IN_READY !== 1'b0) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        OUT_READY = 1'b1;
        #1;
        check("bp_ready_on_release", IN_READY, 1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        get_result(d, lat);
        check("bp_second_data", d, 7680);
        check("bp_second_latency", lat, N + 2);

        // FLUSH mid-MAC, then FLUSH together with IN_VALID in IDLE.
        flush_pulse();
        set_rom(16'h7FFF, 16'h4000);
        send(8'sd100);
        repeat (4) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (OUT_VALID) bad++;
        end
        check("flush_mac_out_valid_cycles", bad, 0);
        check("flush_mac_busy", BUSY, 0);
        @(negedge CLK);
        FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'sd77;
        #1;
        check("flush_in_ready", IN_READY, 0);
        @(negedge CLK);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        check("flush_no_accept_busy", BUSY, 0);
        send(8'sd100);
        get_result(d, lat);
        check("flush_impulse_data", d, 25599);

        // Asynchronous reset in the middle of a computation.
        flush_pulse();
        set_rom(16'h7FFF, 16'h4000);
        send(8'sd50);
        get_result(d, lat);
        check("rstmid_pre_data", d, 12799);
        send(8'sd100);
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        #2;
        check("rstmid_in_ready", IN_READY, 0);
        check("rstmid_out_valid", OUT_VALID, 0);
        check("rstmid_out_data", OUT_DATA, 0);
        check("rstmid_coef_addr", COEF_ADDR, 0);
        check("rstmid_busy", BUSY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("rstmid_waits_idle", BUSY, 0);
        send(8'sd100);
        get_result(d, lat);
        check("rstmid_post_data", d, 25599);

        // EN dropped during MAC: result still delivered, no new accept.
        flush_pulse();
        set_rom(16'h7FFF, 16'h0000);
        send(-8'sd100);
        repeat (3) @(negedge CLK);
        EN = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'sd55;
        get_result(d, lat);
        check("en_low_data", d, -25600);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (IN_READY !== 1'b0) bad++;
        end
        check("en_low_ready_cycles", bad, 0);
        check("en_low_busy", BUSY, 0);
        EN = 1'b1;
        #1;
        check("en_back_ready", IN_READY, 1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        get_result(d, lat);
        check("en_back_data", d, 14079);
        check("en_back_latency", lat, N + 2);

        // Streaming: all taps 0x7FFF, eight samples of 127, OUT_READY held.
        flush_pulse();
        for (int j = 0; j < N; j++) rom[j] = 16'h7FFF;
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        IN_DATA   = 8'sd127;
        nacc = 0;
        nres = 0;
        for (int c = 0; c < 300 && nres < 8; c++) begin
            @(negedge CLK);
            if (nacc == 8) IN_VALID = 1'b0;
            if (OUT_VALID) begin
                res[nres] = OUT_DATA;
                nres++;
            end
            if (IN_VALID && IN_READY && nacc < 8) begin
                acyc[nacc] = c;
                nacc++;
            end
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        check("stream_results", nres, 8);
        check("stream_accepts", nacc, 8);
        if (nres == 8 && nacc == 8) begin
            check("stream_res0", res[0], 32511);
            check("stream_res1", res[1], E_S1);
            check("stream_res7", res[7], E_S7);
            check("stream_interval_first", acyc[1] - acyc[0], N + 3);
            check("stream_interval_last", acyc[7] - acyc[6], N + 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
